icache_axi_rd: RTL and testbench

ICACHE_AXI_RD -- requirements
Module: icache_axi_rd

---
 rtl/icache_axi_rd.sv | 190 +++++++++++++++++++
 tb/tb_icache_axi_rd.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd.sv
// icache_axi_rd: instruction-cache refill engine on an AXI4 read channel.
// One outstanding read at a time. A cached request fetches a 4-word line as an
// INCR burst. An uncached request fetches a single word.
// The returned data is shifted into a 128-bit buffer, one word per beat.
// Optional feature macro: ICACHE_AXI_RD_ERR_CHECK_EN. When it is defined, a
// sticky rd_err flag records bad responses. These are a non-OKAY rresp, a
// foreign rid, or an rlast that does not match the expected final beat.
module icache_axi_rd #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 4
) (
  input  logic         clk_g,
  input  logic         rst,
  // ICache side
  input  logic         rd_req,
  input  logic         rd_uncache,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  // AXI4 read address channel
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  // AXI4 read data channel
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // Sticky error flag
  output logic         rd_err
);

  localparam int         LINE_BITS  = LINE_WORDS * 32;
  localparam logic [7:0] CACHED_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [31:0]            r_addr;
  logic                   r_uncache;
  logic [LINE_BITS-1:0]   r_buf;
  logic [1:0]             r_cnt;

  logic                   w_accept;
  logic                   w_beat;
  logic                   w_last_beat;
  logic [7:0]             w_arlen;

  // A request is taken only while idle.
  assign w_accept    = rd_req && (r_state == S_IDLE);
  // A data beat counts only while the engine is collecting data.
  assign w_beat      = rvalid && (r_state == S_R);
  // The burst length comes from the latched request type.
  assign w_arlen     = r_uncache ? 8'd0 : CACHED_LEN;
  // The burst ends on the beat whose count equals the burst length.
  // rlast is not used for this decision.
  assign w_last_beat = ({6'd0, r_cnt} == w_arlen);

  // State register.
  always_ff @(posedge clk_g) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs. Every output is a function of state
  // only, so no input reaches an output combinationally.
  always_comb begin
    w_state_next = r_state;
    rd_rdy       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    ret_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        rd_rdy = 1'b1;
        if (rd_req) begin
          w_state_next = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_state_next = S_R;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && w_last_beat) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        ret_valid    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Latch the request on acceptance. The AR fields are driven from these
  // registers, so they stay stable for the whole address phase.
  // The reset value selects the uncached encoding with a zero address.
  always_ff @(posedge clk_g) begin
    if (rst) begin
      r_addr    <= 32'd0;
      r_uncache <= 1'b1;
    end else if (w_accept) begin
      r_addr    <= rd_addr;
      r_uncache <= rd_uncache;
    end
  end

  // Shift each data beat into the top of the line buffer and count the beat.
  // The buffer keeps its contents between transactions.
  always_ff @(posedge clk_g) begin
    if (rst) begin
      r_buf <= '0;
      r_cnt <= 2'd0;
    end else begin
      if (w_accept) begin
        r_cnt <= 2'd0;
      end
      if (w_beat) begin
        r_buf <= {rdata, r_buf[LINE_BITS-1:32]};
        r_cnt <= w_last_beat ? 2'd0 : r_cnt + 2'd1;
      end
    end
  end

  assign ret_data = r_buf;

  // Read-address channel fields.
  assign arid    = AXI_ID;
  assign araddr  = r_uncache ? r_addr : {r_addr[31:4], 4'b0000};
  assign arlen   = w_arlen;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = r_uncache ? 4'b0000 : 4'b1111;
  assign arprot  = 3'b000;

`ifdef ICACHE_AXI_RD_ERR_CHECK_EN
  logic r_err;
  logic w_beat_bad;

  // A beat is bad when rresp is not OKAY, when rid does not match AXI_ID,
  // or when rlast does not match the expected final beat.
  assign w_beat_bad = (rresp != 2'b00) || (rid != AXI_ID) ||
                      (rlast != w_last_beat);

  // Sticky error flag. Only reset clears it. The data path is not affected.
  always_ff @(posedge clk_g) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_beat && w_beat_bad) begin
      r_err <= 1'b1;
    end
  end

  assign rd_err = r_err;
`else
  // No checker in this build: the response status fields are not used.
  logic w_unused_resp;
  assign w_unused_resp = ^{rresp, rid, rlast};
  assign rd_err        = 1'b0;
`endif

endmodule

// File: tb/tb_icache_axi_rd.sv
// Testbench for icache_axi_rd.
// The stimulus process drives the ICache request and plays the AXI slave.
// It pushes the expected line into a scoreboard queue when the final beat goes
// out. A monitor process pops and compares whenever ret_valid is seen.
// The expected line comes from a line-level model: a cached line is the four
// words in order, and an uncached word lands on top of the previous line
// shifted down by one word.
`timescale 1ns/1ps
module tb_icache_axi_rd;

`ifdef ICACHE_AXI_RD_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk_g      = 1'b0;
  logic         rst        = 1'b1;
  logic         rd_req     = 1'b0;
  logic         rd_uncache = 1'b0;
  logic [31:0]  rd_addr    = 32'd0;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready    = 1'b0;
  logic [3:0]   rid        = 4'd0;
  logic [31:0]  rdata      = 32'd0;
  logic [1:0]   rresp      = 2'd0;
  logic         rlast      = 1'b0;
  logic         rvalid     = 1'b0;
  logic         rready;
  logic         rd_err;

  always #5 clk_g = ~clk_g;

  icache_axi_rd #(.AXI_ID(4'd0), .LINE_WORDS(4)) dut (
    .clk_g(clk_g), .rst(rst),
    .rd_req(rd_req), .rd_uncache(rd_uncache), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .rd_err(rd_err)
  );

  int           checks     = 0;
  int           failures   = 0;
  int           txn_id     = 0;
  logic [127:0] exp_q[$];
  logic [127:0] model_line = '0;
  logic         exp_err    = 1'b0;
  bit           prev_rv    = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor and scoreboard: compare each returned line, and check the
  // handshake rules around ret_valid.
  always @(negedge clk_g) begin
    logic [127:0] e;
    if (prev_rv) chk("rd_rdy_after_done", rd_rdy, 1);
    if (ret_valid) begin
      chk("rdy_rv_overlap", rd_rdy, 0);
      chk("sb_depth_at_ret", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ret_data", ret_data, e);
        $display("txn %0d ret_data=%h", txn_id, ret_data);
        txn_id++;
      end
    end
    prev_rv = ret_valid;
  end

  // One request plus the slave side of its AXI traffic.
  // err_kind: 0 none, 1 bad rresp, 2 bad rid, 3 flipped rlast (on err_beat).
  // rst_beat >= 0 asserts reset together with that beat.
  task automatic run_txn(input logic unc, input logic [31:0] addr, input logic [127:0] words,
                         input int ar_dly, input int gap, input int err_kind,
                         input int err_beat, input int rst_beat);
    int           n;
    int           t;
    bit           bad;
    logic [31:0]  exp_araddr;
    logic [127:0] exp_line;
    logic [56:0]  exp_ar;
    n          = unc ? 1 : 4;
    exp_araddr = unc ? addr : {addr[31:4], 4'b0000};
    exp_line   = unc ? {words[31:0], model_line[127:32]} : words;
    exp_ar     = {exp_araddr, (unc ? 8'd0 : 8'd3), 3'd2, 2'b01, 1'b0,
                  (unc ? 4'h0 : 4'hF), 3'd0, 4'd0};
    rd_req = 1'b1; rd_uncache = unc; rd_addr = addr;
    t = 0;
    while (!rd_rdy && t < 20) begin
      @(negedge clk_g);
      t++;
    end
    if (!rd_rdy) begin
      chk("rd_rdy_timeout", t, 0);
      rd_req = 1'b0;
      return;
    end
    @(negedge clk_g);
    // Scramble the request inputs: the DUT must use its latched copy.
    rd_req = 1'b0; rd_addr = $urandom; rd_uncache = 1'($urandom);
    chk("arvalid_on_accept", arvalid, 1);
    for (int i = 0; i < ar_dly; i++) begin
      chk("ar_chan_wait", {araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid}, exp_ar);
      chk("rready_in_ar", rready, 0);
      chk("ret_data_hold", ret_data, model_line);
      rvalid = 1'($urandom); rdata = $urandom;   // must be ignored outside R
      @(negedge clk_g);
      chk("arvalid_wait", arvalid, 1);
    end
    rvalid = 1'b0; arready = 1'b1;
    chk("ar_chan", {araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid}, exp_ar);
    @(negedge clk_g);
    arready = 1'b0;
    chk("arvalid_after_hs", arvalid, 0);
    chk("ret_data_hold_r", ret_data, model_line);
    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < gap; g++) begin
        chk("rready_gap", rready, 1);
        @(negedge clk_g);
      end
      bad    = (err_kind != 0) && (b == err_beat);
      rvalid = 1'b1;
      rdata  = words[b*32 +: 32];
      rresp  = (bad && err_kind == 1) ? 2'b10 : 2'b00;
      rid    = (bad && err_kind == 2) ? 4'd5 : 4'd0;
      rlast  = (b == n - 1) ^ (bad && err_kind == 3);
      chk("rready_beat", rready, 1);
      if (b == rst_beat) rst = 1'b1;
      if (b == n - 1 && rst_beat < 0) exp_q.push_back(exp_line);
      @(negedge clk_g);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0;
      if (b == rst_beat) begin
        rst = 1'b0;
        chk("rst_mid_rd_rdy", rd_rdy, 1);
        chk("rst_mid_rready", rready, 0);
        chk("rst_mid_arvalid", arvalid, 0);
        chk("rst_mid_ret_valid", ret_valid, 0);
        chk("rst_mid_ret_data", ret_data, 0);
        chk("rst_mid_ar_fields", {araddr, arlen, arcache}, 0);
        chk("rst_mid_rd_err", rd_err, 0);
        model_line = '0;
        exp_err    = 1'b0;
        $display("txn reset during beat %0d", b);
        return;
      end
      if (bad && ERR_EN) exp_err = 1'b1;
      chk("rd_err", rd_err, exp_err);
      if (b < n - 1) begin
        chk("ret_valid_early", ret_valid, 0);
      end else begin
        chk("ret_valid_pulse", ret_valid, 1);
        chk("rd_rdy_in_done", rd_rdy, 0);
      end
    end
    model_line = exp_line;
  endtask

  initial begin
    repeat (3) @(negedge clk_g);
    chk("reset_rd_rdy", rd_rdy, 1);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_rready", rready, 0);
    chk("reset_ret_valid", ret_valid, 0);
    chk("reset_ret_data", ret_data, 0);
    chk("reset_rd_err", rd_err, 0);
    chk("reset_ar_fields", {araddr, arlen, arcache}, 0);
    rst = 1'b0;
    @(negedge clk_g);

    // Cached line, immediate arready, back-to-back beats.
    run_txn(1'b0, 32'h1FC0_0010, 128'h00000044_00000033_00000022_00000011, 0, 0, 0, 0, -1);
    @(negedge clk_g);
    // Uncached word.
    run_txn(1'b1, 32'hBFC0_0004, {96'd0, 32'hDEAD_BEEF}, 0, 0, 0, 0, -1);
    @(negedge clk_g);
    // Slow slave: arready late, gaps between beats.
    run_txn(1'b0, 32'h8000_0120, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 5, 2, 0, 0, -1);
    // Back-to-back: the next request is raised while the DUT is in DONE.
    run_txn(1'b0, 32'h0000_1000, 128'h44444444_33333333_22222222_11111111, 0, 0, 0, 0, -1);
    run_txn(1'b1, 32'h0000_2008, {96'd0, 32'hCAFE_F00D}, 1, 0, 0, 0, -1);
    // Error responses: the error is sticky across later clean transfers.
    run_txn(1'b0, 32'h0000_3000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 0, 0, 1, 0, -1);
    run_txn(1'b0, 32'h0000_3010, 128'h1D1D1D1D_1C1C1C1C_1B1B1B1B_1A1A1A1A, 0, 1, 0, 0, -1);
    run_txn(1'b1, 32'h0000_3024, {96'd0, 32'h1234_5678}, 0, 0, 2, 0, -1);
    run_txn(1'b0, 32'h0000_3040, 128'h2D2D2D2D_2C2C2C2C_2B2B2B2B_2A2A2A2A, 0, 0, 3, 2, -1);
    @(negedge clk_g);
    // Reset during the second beat of a cached refill.
    run_txn(1'b0, 32'h0000_4000, 128'h3D3D3D3D_3C3C3C3C_3B3B3B3B_3A3A3A3A, 1, 1, 0, 0, 1);
    @(negedge clk_g);

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      logic         u;
      logic [31:0]  a;
      logic [127:0] w;
      u = 1'($urandom_range(0, 1));
      a = $urandom;
      if (!u) a[3:0] = 4'd0;
      w = {$urandom, $urandom, $urandom, $urandom};
      run_txn(u, a, w, $urandom_range(0, 3), $urandom_range(0, 2), 0, 0, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk_g);
    end

    repeat (3) @(negedge clk_g);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
